// File: rtl/cart_rom_loader_pkg.sv
// Shared types, defaults and helpers for the cartridge ROM download loader.
package cart_rom_loader_pkg;

    localparam int LDR_ADDR_W     = 25;
    localparam int LDR_FIFO_DEPTH = 8;
    localparam int LDR_WR_GAP     = 2;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_FETCH,
        LDR_EMIT_LO,
        LDR_STROBE,
        LDR_GAP,
        LDR_EMIT_HI,
        LDR_CLOSE,
        LDR_DRAIN
    } ldr_state_e;

    function automatic logic [7:0] pickByte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/cart_rom_loader_fifo.sv
// Synchronous word FIFO with a registered read port and full/empty flags.
module cart_rom_loader_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         wrEn_i,
    input  logic [W-1:0] wrData_i,
    input  logic         rdEn_i,
    output logic [W-1:0] rdData_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wrPtr_q;
    logic [PW:0]  rdPtr_q;
    logic [W-1:0] rdData_q;
    logic         doPush;
    logic         doPop;

    assign empty_o  = (wrPtr_q == rdPtr_q);
    assign full_o   = (wrPtr_q[PW] != rdPtr_q[PW]) && (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
    assign doPop    = rdEn_i & ~empty_o;
    // A full FIFO still takes a word when one leaves in the same cycle.
    assign doPush   = wrEn_i & (~full_o | doPop);
    assign rdData_o = rdData_q;

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q[PW-1:0]] <= wrData_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            rdData_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q  <= rdPtr_q + 1'b1;
                rdData_q <= mem_q[rdPtr_q[PW-1:0]];
            end
        end
    end

endmodule

// File: rtl/cart_rom_loader.sv
// Splits host download words into paced ioctl byte writes for the cartridge ROM,
// framing the transfer with ioctl_isROM and closing it after src_len bytes.
module cart_rom_loader
    import cart_rom_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = LDR_FIFO_DEPTH,
    parameter int ADDR_W     = LDR_ADDR_W,
    parameter int WR_GAP     = LDR_WR_GAP
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              src_start_i,
    input  logic [ADDR_W-1:0] src_len_i,
    input  logic              src_valid_i,
    input  logic [15:0]       src_data_i,
    output logic              src_ready_o,
    output logic              ioctl_wr_o,
    output logic [ADDR_W-1:0] ioctl_addr_o,
    output logic [7:0]        ioctl_dout_o,
    output logic              ioctl_isROM_o,
    input  logic              ioctl_wait_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int             GW    = $clog2(WR_GAP + 2);
    localparam logic [GW-1:0]  GAP_N = GW'(WR_GAP);

    ldr_state_e        state_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] sent_q;
    logic [7:0]        dout_q;
    logic [7:0]        hiByte_q;
    logic              hiPending_q;
    logic              wr_q;
    logic              isRom_q;
    logic              busy_q;
    logic              done_q;
    logic [GW-1:0]     gapCnt_q;

    logic              fifoPush;
    logic              fifoPop;
    logic              fetchPop;
    logic [15:0]       fifoData;
    logic              fifoFull;
    logic              fifoEmpty;

    // Surplus words are still acknowledged while draining but never stored.
    assign src_ready_o = (busy_q & ~fifoFull) | (state_q == LDR_DRAIN);
    assign fifoPush    = src_valid_i & src_ready_o & (state_q != LDR_DRAIN);
    assign fetchPop    = (state_q == LDR_FETCH) & ~fifoEmpty & ~ioctl_wait_i;
    assign fifoPop     = fetchPop | ((state_q == LDR_DRAIN) & ~fifoEmpty);

    assign ioctl_wr_o    = wr_q;
    assign ioctl_addr_o  = addr_q;
    assign ioctl_dout_o  = dout_q;
    assign ioctl_isROM_o = isRom_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

    cart_rom_loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .wrEn_i   (fifoPush),
        .wrData_i (src_data_i),
        .rdEn_i   (fifoPop),
        .rdData_o (fifoData),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

    // Data is loaded one state ahead of STROBE so address and byte are settled before the pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= LDR_IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            sent_q      <= '0;
            dout_q      <= '0;
            hiByte_q    <= '0;
            hiPending_q <= 1'b0;
            wr_q        <= 1'b0;
            isRom_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gapCnt_q    <= '0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            if (wr_q) begin
                addr_q <= addr_q + 1'b1;
                sent_q <= sent_q + 1'b1;
            end
            case (state_q)
                LDR_IDLE: begin
                    if (src_start_i) begin
                        len_q       <= src_len_i;
                        addr_q      <= '0;
                        sent_q      <= '0;
                        hiPending_q <= 1'b0;
                        isRom_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= (src_len_i == '0) ? LDR_CLOSE : LDR_FETCH;
                    end
                end
                LDR_FETCH: begin
                    if (fetchPop) begin
                        state_q <= LDR_EMIT_LO;
                    end
                end
                LDR_EMIT_LO: begin
                    dout_q      <= pickByte(fifoData, 1'b0);
                    hiByte_q    <= pickByte(fifoData, 1'b1);
                    hiPending_q <= 1'b1;
                    state_q     <= LDR_STROBE;
                end
                LDR_EMIT_HI: begin
                    dout_q      <= hiByte_q;
                    hiPending_q <= 1'b0;
                    state_q     <= LDR_STROBE;
                end
                LDR_STROBE: begin
                    if (!ioctl_wait_i) begin
                        wr_q     <= 1'b1;
                        gapCnt_q <= '0;
                        state_q  <= LDR_GAP;
                    end
                end
                LDR_GAP: begin
                    if (gapCnt_q != GAP_N) begin
                        gapCnt_q <= gapCnt_q + 1'b1;
                    end else if (!wr_q && !ioctl_wait_i) begin
                        if (sent_q == len_q) begin
                            state_q <= LDR_CLOSE;
                        end else if (hiPending_q) begin
                            state_q <= LDR_EMIT_HI;
                        end else begin
                            state_q <= LDR_FETCH;
                        end
                    end
                end
                LDR_CLOSE: begin
                    if (!ioctl_wait_i) begin
                        isRom_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= LDR_DRAIN;
                    end
                end
                LDR_DRAIN: begin
                    if (fifoEmpty) begin
                        state_q <= LDR_IDLE;
                    end
                end
                default: state_q <= LDR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_rom_loader.sv
// Randomized self-checking bench: each load's byte stream is predicted from the pushed
// words and src_len, then every ioctl strobe and window event is compared against it.
module tb_cart_rom_loader;

    localparam int ADDR_W     = 25;
    localparam int FIFO_DEPTH = 8;
    localparam int WR_GAP     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              srcStart;
    logic [ADDR_W-1:0] srcLen;
    logic              srcValid;
    logic [15:0]       srcData;
    logic              srcReady;
    logic              ioctlWr;
    logic [ADDR_W-1:0] ioctlAddr;
    logic [7:0]        ioctlDout;
    logic              ioctlIsRom;
    logic              ioctlWait;
    logic              busy;
    logic              done;

    int checks = 0;
    int failures = 0;
    int strobeCnt = 0;
    int doneCnt = 0;
    int accepted = 0;
    int cycle = 0;
    int lastWrCycle = 0;
    int stallLeft = 0;
    int waitMode = 0;
    bit isRomSeen = 0;
    bit abortLoad = 0;
    bit pushDone = 0;
    bit waitForce = 0;

    logic [7:0]        expData[$];
    logic [15:0]       presetWords[$];
    logic [ADDR_W-1:0] prevAddr = '0;
    logic [7:0]        prevDout = '0;
    logic              prevIsRom = 1'b0;

    always #5 clk = ~clk;

    cart_rom_loader #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .WR_GAP     (WR_GAP)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .src_start_i   (srcStart),
        .src_len_i     (srcLen),
        .src_valid_i   (srcValid),
        .src_data_i    (srcData),
        .src_ready_o   (srcReady),
        .ioctl_wr_o    (ioctlWr),
        .ioctl_addr_o  (ioctlAddr),
        .ioctl_dout_o  (ioctlDout),
        .ioctl_isROM_o (ioctlIsRom),
        .ioctl_wait_i  (ioctlWait),
        .busy_o        (busy),
        .done_o        (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Sink side: checks every strobe against the predicted byte stream and plays SDRAM backpressure.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cycle++;
            if (reset) begin
                stallLeft = 0;
            end else begin
                checkOutput("wrDuringWait", 32'(ioctlWr & ioctlWait), 32'd0);
                if (ioctlWr) begin
                    checkOutput("strobeInWindow", 32'(strobeCnt < expData.size()), 32'd1);
                    if (strobeCnt < expData.size()) begin
                        checkOutput("addr", 32'(ioctlAddr), 32'(strobeCnt));
                        checkOutput("dout", 32'(ioctlDout), 32'(expData[strobeCnt]));
                        checkOutput("addrSetup", 32'(prevAddr), 32'(strobeCnt));
                        checkOutput("doutSetup", 32'(prevDout), 32'(expData[strobeCnt]));
                    end
                    checkOutput("isRomAtWr", 32'(ioctlIsRom), 32'd1);
                    checkOutput("isRomBeforeWr", 32'(prevIsRom), 32'd1);
                    if (strobeCnt > 0) begin
                        checkOutput("wrSpacing", 32'((cycle - lastWrCycle) > WR_GAP), 32'd1);
                    end
                    if (waitMode == 2 && strobeCnt == 1) begin
                        checkOutput("stallSpacing", 32'((cycle - lastWrCycle) > 10), 32'd1);
                    end
                    lastWrCycle = cycle;
                    strobeCnt++;
                end
                if (ioctlIsRom) begin
                    isRomSeen = 1;
                end
                if (done) begin
                    doneCnt++;
                    checkOutput("doneStrobes", 32'(strobeCnt), 32'(expData.size()));
                    checkOutput("isRomAtDone", 32'(ioctlIsRom), 32'd0);
                end
                if (waitMode == 2 && stallLeft > 0 && expData.size() > 0) begin
                    checkOutput("stallDout", 32'(ioctlDout), 32'(expData[0]));
                    checkOutput("stallAddr", 32'(ioctlAddr), 32'd1);
                end
                if (ioctlWr && waitMode == 2 && strobeCnt == 1) begin
                    stallLeft = 10;
                end else if (ioctlWr && waitMode == 1 && $urandom_range(0, 1) == 1) begin
                    stallLeft = $urandom_range(1, 6);
                end else if (stallLeft > 0) begin
                    stallLeft--;
                end
            end
            ioctlWait = waitForce || (stallLeft > 0);
            prevAddr  = ioctlAddr;
            prevDout  = ioctlDout;
            prevIsRom = ioctlIsRom;
        end
    end

    task automatic pushWords(input logic [15:0] words[$]);
        for (int i = 0; i < words.size(); i++) begin
            int tries = 0;
            srcValid = 1'b1;
            srcData  = words[i];
            #1;
            while (!srcReady && !abortLoad && tries < 500) begin
                @(negedge clk);
                #1;
                tries++;
            end
            if (abortLoad) break;
            if (!srcReady) begin
                checkOutput("srcAccept", 32'(srcReady), 32'd1);
                break;
            end
            accepted++;
            @(negedge clk);
            srcValid = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        srcValid = 1'b0;
        pushDone = 1;
    endtask

    task automatic waitForEnd(input int len, input bit fill, input int resetAfter, input bit busyStart);
        int cyc = 0;
        bit startSent = 0;
        if (fill) begin
            repeat (40) @(negedge clk);
            #1;
            checkOutput("fillAccepted", 32'(accepted), 32'(FIFO_DEPTH));
            checkOutput("fillReady", 32'(srcReady), 32'd0);
            waitForce = 0;
        end
        while (doneCnt == 0 && cyc < 4000) begin
            @(negedge clk);
            #1;
            cyc++;
            srcStart = 1'b0;
            if (busyStart && !startSent && strobeCnt == 2) begin
                srcStart  = 1'b1;
                srcLen    = ADDR_W'(len + 4);
                startSent = 1;
            end
            if (resetAfter > 0 && strobeCnt >= resetAfter) begin
                abortLoad = 1;
                reset     = 1'b1;
                #1;
                checkOutput("rstWr", 32'(ioctlWr), 32'd0);
                checkOutput("rstAddr", 32'(ioctlAddr), 32'd0);
                checkOutput("rstDout", 32'(ioctlDout), 32'd0);
                checkOutput("rstIsRom", 32'(ioctlIsRom), 32'd0);
                checkOutput("rstBusy", 32'(busy), 32'd0);
                checkOutput("rstDone", 32'(done), 32'd0);
                checkOutput("rstReady", 32'(srcReady), 32'd0);
                repeat (2) @(negedge clk);
                reset = 1'b0;
                cyc = 0;
                while (!pushDone && cyc < 1000) begin
                    @(negedge clk);
                    cyc++;
                end
                checkOutput("pushAborted", 32'(pushDone), 32'd1);
                return;
            end
        end
        srcStart = 1'b0;
        checkOutput("doneCount", 32'(doneCnt), 32'd1);
        cyc = 0;
        while (!pushDone && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("pushFinished", 32'(pushDone), 32'd1);
        repeat (12) @(negedge clk);
        #1;
        checkOutput("endBusy", 32'(busy), 32'd0);
        checkOutput("endIsRom", 32'(ioctlIsRom), 32'd0);
        checkOutput("endReady", 32'(srcReady), 32'd0);
        checkOutput("endStrobes", 32'(strobeCnt), 32'(len));
        checkOutput("endDoneCount", 32'(doneCnt), 32'd1);
        checkOutput("isRomSeen", 32'(isRomSeen), 32'd1);
    endtask

    // One download: predict the byte stream from the words and length, start, feed, and track.
    task automatic applyStimulus(input int len, input int surplus, input int mode,
                                 input bit fill, input int resetAfter, input bit busyStart);
        logic [15:0] words[$];
        logic [15:0] w;
        int nWords;
        nWords = (len + 1) / 2 + surplus;
        for (int i = 0; i < nWords; i++) begin
            if (i < presetWords.size()) words.push_back(presetWords[i]);
            else                        words.push_back(16'($urandom));
        end
        presetWords.delete();
        expData.delete();
        for (int i = 0; i < len; i++) begin
            w = words[i / 2];
            expData.push_back((i % 2 == 1) ? w[15:8] : w[7:0]);
        end
        strobeCnt = 0;
        doneCnt   = 0;
        accepted  = 0;
        isRomSeen = 0;
        abortLoad = 0;
        pushDone  = 0;
        waitMode  = mode;
        @(negedge clk);
        srcStart = 1'b1;
        srcLen   = ADDR_W'(len);
        @(negedge clk);
        srcStart = 1'b0;
        fork
            pushWords(words);
            waitForEnd(len, fill, resetAfter, busyStart);
        join
        waitMode = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int len;
        reset     = 1'b1;
        srcStart  = 1'b0;
        srcLen    = '0;
        srcValid  = 1'b0;
        srcData   = '0;
        ioctlWait = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("resetWr", 32'(ioctlWr), 32'd0);
        checkOutput("resetAddr", 32'(ioctlAddr), 32'd0);
        checkOutput("resetDout", 32'(ioctlDout), 32'd0);
        checkOutput("resetIsRom", 32'(ioctlIsRom), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetReady", 32'(srcReady), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("idleReady", 32'(srcReady), 32'd0);

        $display("[TB] basic four-byte load");
        presetWords.push_back(16'h2211);
        presetWords.push_back(16'h4433);
        applyStimulus(4, 0, 0, 0, 0, 0);

        $display("[TB] odd length drops final high byte");
        presetWords.push_back(16'hBBAA);
        presetWords.push_back(16'hDDCC);
        applyStimulus(3, 0, 0, 0, 0, 0);

        $display("[TB] ten-cycle stall after first strobe");
        applyStimulus(6, 0, 2, 0, 0, 0);

        $display("[TB] FIFO fill under held wait");
        waitForce = 1;
        repeat (2) @(negedge clk);
        applyStimulus(20, 0, 0, 1, 0, 0);

        $display("[TB] reset mid-download then reload");
        applyStimulus(16, 0, 1, 0, 5, 0);
        applyStimulus(6, 0, 0, 0, 0, 0);

        $display("[TB] zero-length window and ignored restart");
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(10, 1, 1, 0, 0, 1);

        $display("[TB] randomized loads");
        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(1, 24);
            applyStimulus(len, (len >= 4) ? $urandom_range(0, 2) : 0, 1, 0, 0,
                          (len >= 6) && ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
